// File: rtl/matmul_seq_ctrl.sv
// rtl/matmul_seq_ctrl.sv - job sequencer feeding a 3x3 MAC array and returning C = A x B
module matmul_seq_ctrl #(
    parameter int DW      = 4,
    parameter int RW      = 10,
    parameter int MAC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [9*DW-1:0]   a_flat,
    input  logic [9*DW-1:0]   b_flat,
    output logic              busy,
    output logic [DW-1:0]     data_w1,
    output logic [DW-1:0]     data_w2,
    output logic [DW-1:0]     data_w3,
    output logic [DW-1:0]     data_x1,
    output logic [DW-1:0]     data_x2,
    output logic [DW-1:0]     data_x3,
    output logic              load,
    output logic              clear,
    input  logic [9*RW-1:0]   acc_in,
    output logic [9*RW-1:0]   res_flat,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        jobs_done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] LAT_LAST = 3'(MAC_LAT - 1);

    logic [2:0]       state;
    logic [1:0]       k;
    logic [2:0]       lat_cnt;
    logic [9*DW-1:0]  a_lat;
    logic [9*DW-1:0]  b_lat;
    logic [1:0]       k_next;
    logic [DW-1:0]    w1_n, w2_n, w3_n, x1_n, x2_n, x3_n;

    // Element (r,c) of a row-major packed 3x3 operand matrix.
    function automatic logic [DW-1:0] elem(input logic [9*DW-1:0] m,
                                           input logic [1:0] r,
                                           input logic [1:0] c);
        int idx;
        idx = 3 * int'(r) + int'(c);
        return m[DW*idx +: DW];
    endfunction

    // Column/row index of the operand slice presented on the next FEED cycle.
    always_comb begin
        k_next = (state == S_CLR) ? 2'd0 : k + 2'd1;
        w1_n   = elem(a_lat, 2'd0, k_next);
        w2_n   = elem(a_lat, 2'd1, k_next);
        w3_n   = elem(a_lat, 2'd2, k_next);
        x1_n   = elem(b_lat, k_next, 2'd0);
        x2_n   = elem(b_lat, k_next, 2'd1);
        x3_n   = elem(b_lat, k_next, 2'd2);
    end

    // Job FSM; every array-facing output is a flop updated together with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= 2'd0;
            lat_cnt   <= 3'd0;
            a_lat     <= '0;
            b_lat     <= '0;
            busy      <= 1'b0;
            load      <= 1'b0;
            clear     <= 1'b0;
            data_w1   <= '0;
            data_w2   <= '0;
            data_w3   <= '0;
            data_x1   <= '0;
            data_x2   <= '0;
            data_x3   <= '0;
            res_flat  <= '0;
            res_valid <= 1'b0;
            jobs_done <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_lat <= a_flat;
                        b_lat <= b_flat;
                        busy  <= 1'b1;
                        clear <= 1'b1;
                        state <= S_CLR;
                    end
                end
                S_CLR: begin
                    clear   <= 1'b0;
                    load    <= 1'b1;
                    k       <= k_next;
                    data_w1 <= w1_n;
                    data_w2 <= w2_n;
                    data_w3 <= w3_n;
                    data_x1 <= x1_n;
                    data_x2 <= x2_n;
                    data_x3 <= x3_n;
                    state   <= S_FEED;
                end
                S_FEED: begin
                    if (k == 2'd2) begin
                        load    <= 1'b0;
                        data_w1 <= '0;
                        data_w2 <= '0;
                        data_w3 <= '0;
                        data_x1 <= '0;
                        data_x2 <= '0;
                        data_x3 <= '0;
                        lat_cnt <= 3'd0;
                        state   <= S_DRAIN;
                    end else begin
                        k       <= k_next;
                        data_w1 <= w1_n;
                        data_w2 <= w2_n;
                        data_w3 <= w3_n;
                        data_x1 <= x1_n;
                        data_x2 <= x2_n;
                        data_x3 <= x3_n;
                    end
                end
                S_DRAIN: begin
                    if (lat_cnt == LAT_LAST) begin
                        res_flat  <= acc_in;
                        res_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    // A start arriving alongside res_ready is dropped; the next job needs IDLE.
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        jobs_done <= jobs_done + 8'd1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    load      <= 1'b0;
                    clear     <= 1'b0;
                    res_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// tb/tb_matmul_seq_ctrl.sv - directed table-driven bench for matmul_seq_ctrl with a MAC array model
module tb_matmul_seq_ctrl;

    localparam int DW      = 4;
    localparam int RW      = 10;
    localparam int MAC_LAT = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [9*DW-1:0] a_flat, b_flat;
    logic            busy;
    logic [DW-1:0]   data_w1, data_w2, data_w3, data_x1, data_x2, data_x3;
    logic            load, clear;
    logic [9*RW-1:0] acc_in;
    logic [9*RW-1:0] res_flat;
    logic            res_valid;
    logic            res_ready;
    logic [7:0]      jobs_done;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    matmul_seq_ctrl #(.DW(DW), .RW(RW), .MAC_LAT(MAC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_flat(a_flat), .b_flat(b_flat),
        .busy(busy), .data_w1(data_w1), .data_w2(data_w2), .data_w3(data_w3),
        .data_x1(data_x1), .data_x2(data_x2), .data_x3(data_x3),
        .load(load), .clear(clear), .acc_in(acc_in), .res_flat(res_flat),
        .res_valid(res_valid), .res_ready(res_ready), .jobs_done(jobs_done)
    );

    // Behavioural 3x3 MAC array: output settles one edge after the last load.
    logic [RW-1:0] acc [9];

    function automatic logic [DW-1:0] wsel(input int i);
        return (i == 0) ? data_w1 : (i == 1) ? data_w2 : data_w3;
    endfunction

    function automatic logic [DW-1:0] xsel(input int j);
        return (j == 0) ? data_x1 : (j == 1) ? data_x2 : data_x3;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                if (clear)
                    acc[3*i+j] <= '0;
                else if (load)
                    acc[3*i+j] <= acc[3*i+j] + RW'(wsel(i)) * RW'(xsel(j));
    end

    always_comb begin
        acc_in = '0;
        for (int e = 0; e < 9; e++) acc_in[RW*e +: RW] = acc[e];
    end

    typedef struct {
        logic [9*DW-1:0] a;
        logic [9*DW-1:0] b;
        logic [9*RW-1:0] c;
    } vec_t;

    vec_t tbl [5];
    vec_t ident;

    function automatic logic [9*DW-1:0] pk_d(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        logic [9*DW-1:0] r;
        r = {DW'(e8), DW'(e7), DW'(e6), DW'(e5), DW'(e4), DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
        return r;
    endfunction

    function automatic logic [9*RW-1:0] pk_r(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
        logic [9*RW-1:0] r;
        r = {RW'(e8), RW'(e7), RW'(e6), RW'(e5), RW'(e4), RW'(e3), RW'(e2), RW'(e1), RW'(e0)};
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({busy, load, clear, data_w1, data_w2, data_w3, data_x1, data_x2, data_x3,
                     res_valid, res_flat, jobs_done});
    endfunction

    // One job with res_ready high; n counts negedges after the accept edge T (n=0 -> after T).
    task automatic run_job(input vec_t v, input string tag);
        logic [39:0]   clr_mask, load_mask;
        logic [DW-1:0] w1s [3];
        logic [DW-1:0] x2s [3];
        logic [7:0]    jd0;
        int            vfirst, vcnt;
        bit            finished;
        clr_mask = '0; load_mask = '0; vfirst = -1; vcnt = 0; finished = 0;
        for (int q = 0; q < 3; q++) begin w1s[q] = '0; x2s[q] = '0; end
        @(negedge clk);
        a_flat = v.a; b_flat = v.b; start = 1'b1; res_ready = 1'b1;
        jd0 = jobs_done;
        @(posedge clk);
        #1;
        start = 1'b0; a_flat = '0; b_flat = '0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            clr_mask[n]  = clear;
            load_mask[n] = load;
            if (load && n >= 1 && n <= 3) begin
                w1s[n-1] = data_w1;
                x2s[n-1] = data_x2;
            end
            if (res_valid) begin
                if (vfirst < 0) vfirst = n;
                vcnt++;
            end
            if (!busy && vfirst >= 0) begin
                finished = 1;
                break;
            end
        end
        chk({tag, "_finished"}, 128'(finished), 128'(1));
        chk({tag, "_clear_window"}, 128'(clr_mask), 128'(40'b0001));
        chk({tag, "_load_window"}, 128'(load_mask), 128'(40'b1110));
        chk({tag, "_valid_rise"}, 128'(vfirst), 128'(4 + MAC_LAT));
        chk({tag, "_valid_cycles"}, 128'(vcnt), 128'(1));
        chk({tag, "_res_flat"}, 128'(res_flat), 128'(v.c));
        chk({tag, "_jobs_done"}, 128'(jobs_done), 128'(jd0 + 8'd1));
        for (int q = 0; q < 3; q++) begin
            chk({tag, "_w1_seq"}, 128'(w1s[q]), 128'(v.a[DW*q +: DW]));
            chk({tag, "_x2_seq"}, 128'(x2s[q]), 128'(v.b[DW*(3*q+1) +: DW]));
        end
    endtask

    initial begin
        logic [9*RW-1:0] held;
        int              errs, wait_n;
        int              prev_acc, bad_int, bad_res, done_cnt, cyc;
        logic            pbusy;
        logic [7:0]      jd_before, jd255;

        tbl[0].a = pk_d(1,0,0, 0,1,0, 0,0,1);
        tbl[0].b = pk_d(1,2,3, 4,5,6, 7,8,9);
        tbl[0].c = pk_r(1,2,3, 4,5,6, 7,8,9);
        tbl[1].a = pk_d(15,15,15, 15,15,15, 15,15,15);
        tbl[1].b = pk_d(15,15,15, 15,15,15, 15,15,15);
        tbl[1].c = pk_r(675,675,675, 675,675,675, 675,675,675);
        tbl[2].a = pk_d(1,2,3, 4,5,6, 7,8,9);
        tbl[2].b = pk_d(1,4,7, 2,5,8, 3,6,9);
        tbl[2].c = pk_r(14,32,50, 32,77,122, 50,122,194);
        tbl[3].a = pk_d(2,0,1, 0,3,0, 1,1,1);
        tbl[3].b = pk_d(1,2,0, 0,1,4, 3,0,2);
        tbl[3].c = pk_r(5,4,2, 0,3,12, 4,3,6);
        tbl[4].a = pk_d(0,0,0, 0,0,0, 0,0,0);
        tbl[4].b = pk_d(1,2,3, 4,5,6, 7,8,9);
        tbl[4].c = pk_r(0,0,0, 0,0,0, 0,0,0);
        ident.a  = pk_d(1,0,0, 0,1,0, 0,0,1);
        ident.b  = pk_d(1,0,0, 0,1,0, 0,0,1);
        ident.c  = pk_r(1,0,0, 0,1,0, 0,0,1);

        start = 1'b0; a_flat = '0; b_flat = '0; res_ready = 1'b0;
        do_reset();
        chk("reset_outputs", all_outs(), 128'(0));

        for (int t = 0; t < 5; t++) run_job(tbl[t], $sformatf("job%0d", t));

        // Consumer stalls for 20 cycles; a start pulse during the stall is ignored.
        @(negedge clk);
        a_flat = tbl[0].a; b_flat = tbl[0].b; start = 1'b1; res_ready = 1'b0;
        jd_before = jobs_done;
        @(posedge clk);
        #1 start = 1'b0;
        wait_n = 0;
        while (!res_valid && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        chk("hold_valid_seen", 128'(res_valid), 128'(1));
        held = res_flat;
        chk("hold_res_flat", 128'(held), 128'(tbl[0].c));
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start = (c == 5);
            if (!res_valid || res_flat !== held || !busy) errs++;
        end
        start = 1'b0;
        chk("hold_stable", 128'(errs), 128'(0));
        res_ready = 1'b1;
        @(negedge clk);
        chk("hold_release_valid", 128'(res_valid), 128'(0));
        chk("hold_release_busy", 128'(busy), 128'(0));
        @(negedge clk);
        chk("hold_start_ignored", 128'(busy), 128'(0));
        chk("hold_jobs_done", 128'(jobs_done), 128'(jd_before + 8'd1));

        // Asynchronous reset during the second FEED cycle discards the job.
        @(negedge clk);
        a_flat = tbl[2].a; b_flat = tbl[2].b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_in_feed_k1", 128'({load, data_w1}), 128'({1'b1, 4'd2}));
        #1 rst_n = 1'b0;
        #1 chk("midrst_outputs", all_outs(), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_job(ident, "post_rst");
        chk("post_rst_count", 128'(jobs_done), 128'(1));

        // 256 jobs back to back with start and res_ready held high.
        do_reset();
        a_flat = tbl[1].a; b_flat = tbl[1].b; start = 1'b1; res_ready = 1'b1;
        prev_acc = -1; bad_int = 0; bad_res = 0; done_cnt = 0; cyc = 0; pbusy = 1'b0;
        jd255 = '0;
        while (done_cnt < 256 && cyc < 2200) begin
            @(negedge clk);
            cyc++;
            if (busy && !pbusy) begin
                if (prev_acc >= 0 && cyc - prev_acc != 6 + MAC_LAT) bad_int++;
                prev_acc = cyc;
            end
            pbusy = busy;
            if (res_valid) begin
                if (res_flat !== tbl[1].c) bad_res++;
                done_cnt++;
                if (done_cnt == 256) jd255 = jobs_done;
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("b2b_completions", 128'(done_cnt), 128'(256));
        chk("b2b_interval", 128'(bad_int), 128'(0));
        chk("b2b_results", 128'(bad_res), 128'(0));
        chk("b2b_count_255", 128'(jd255), 128'(255));
        chk("b2b_wrap", 128'(jobs_done), 128'(0));
        chk("b2b_idle", 128'(busy), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
